// File: rtl/onchip_mem_stream_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them to on-chip RAM from a base address.
// Latency: one write cycle after the 4th (or final) byte; done follows the last write by one cycle.
// Backpressure: in_ready is held low outside FILL, so the source stalls during WRITE, DONE and IDLE.
module onchip_mem_stream_loader #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DEPTH       = 8192,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] byte_count,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [3:0]             mem_byteenable,
    output logic                   mem_chipselect,
    output logic                   mem_write,
    output logic [31:0]            mem_writedata,
    output logic                   mem_clken,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDR_WIDTH:0]    words_written
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  word_addr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [1:0]             lane;
    logic [31:0]            pack;
    logic [3:0]             lane_en;
    logic [ADDR_WIDTH:0]    wr_cnt;
    logic                   err_q;
    logic                   clken_q;
    logic [31:0]            room;
    logic                   start_zero;
    logic                   start_bad;
    logic                   accept;
    logic                   last_byte;

    // Bytes of space left from base to the top of RAM, computed wide so it never truncates.
    assign room       = (32'(DEPTH) - 32'(base_addr)) << 2;
    assign start_zero = (byte_count == '0);
    assign start_bad  = (32'(byte_count) > room);
    assign accept     = (state == FILL) && in_valid;
    assign last_byte  = (remaining == COUNT_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_zero)     state_nxt = DONE;
                    else if (start_bad) state_nxt = IDLE;
                    else                state_nxt = FILL;
                end
            end
            FILL: begin
                if (accept && (lane == 2'd3 || last_byte)) state_nxt = WRITE;
            end
            WRITE:   state_nxt = (remaining == '0) ? DONE : FILL;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready       = (state == FILL);
        busy           = (state == FILL) || (state == WRITE);
        done           = (state == DONE);
        mem_chipselect = (state == WRITE);
        mem_write      = (state == WRITE);
        mem_byteenable = (state == WRITE) ? lane_en : 4'b0000;
        mem_writedata  = (state == WRITE) ? pack : 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_addr <= '0;
            remaining <= '0;
            lane      <= '0;
            pack      <= '0;
            lane_en   <= '0;
            wr_cnt    <= '0;
            err_q     <= 1'b0;
            clken_q   <= 1'b0;
        end else begin
            clken_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        word_addr <= base_addr;
                        remaining <= byte_count;
                        wr_cnt    <= '0;
                        err_q     <= !start_zero && start_bad;
                        lane      <= '0;
                        pack      <= '0;
                        lane_en   <= '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        pack[{lane, 3'b000} +: 8] <= in_data;
                        lane_en[lane]             <= 1'b1;
                        lane                      <= lane + 2'd1;
                        remaining                 <= remaining - COUNT_WIDTH'(1);
                    end
                end
                WRITE: begin
                    wr_cnt  <= wr_cnt + (ADDR_WIDTH+1)'(1);
                    pack    <= '0;
                    lane_en <= '0;
                    // Advance only when more data follows, so DONE still shows the last written address.
                    if (remaining != '0) word_addr <= word_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign mem_address   = word_addr;
    assign mem_clken     = clken_q;
    assign error         = err_q;
    assign words_written = wr_cnt;

endmodule

// File: tb/tb_onchip_mem_stream_loader.sv
// Randomized and directed loads checked against a queue of expected RAM writes built from the byte list.
module tb_onchip_mem_stream_loader;
    localparam int AW    = 13;
    localparam int DEPTH = 8192;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] byte_count = '0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect;
    logic          mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_clken;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_written;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        obs_q[$];
    logic [7:0] dir_bytes[$];
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    onchip_mem_stream_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .byte_count(byte_count), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Every RAM write is matched in order against the expected-write queue.
    always @(negedge clk) begin : cmp
        wr_t o;
        wr_t e;
        if (reset_n && mem_write) begin
            o.addr = mem_address;
            o.data = mem_writedata;
            o.be   = mem_byteenable;
            obs_q.push_back(o);
            chk("cs_with_write", 64'(mem_chipselect), 64'd1);
            chk("in_ready_in_write", 64'(in_ready), 64'd0);
            chk("busy_in_write", 64'(busy), 64'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(mem_address), 64'h1_0000_0000);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(o.addr), 64'(e.addr));
                chk("wr_data", 64'(o.data), 64'(e.data));
                chk("wr_be", 64'(o.be), 64'(e.be));
            end
        end else if (reset_n && mem_chipselect) begin
            chk("stray_chipselect", 64'(mem_chipselect), 64'd0);
        end
    end

    task automatic do_load(input logic [AW-1:0] base, input logic [CW-1:0] cnt,
                           input int gmin, input int gmax, input bit poke);
        logic [7:0] b[$];
        wr_t        w;
        int         nw;
        int         t;
        bit         bad;
        bit         seen;
        bad = (int'(cnt) > (DEPTH - int'(base)) * 4);
        b = {};
        for (int i = 0; i < int'(cnt); i++)
            b.push_back(dir_bytes.size() == int'(cnt) ? dir_bytes[i] : 8'($urandom));
        obs_q = {};
        nw = bad ? 0 : (int'(cnt) + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            w.addr = base + AW'(wi);
            w.data = '0;
            w.be   = '0;
            for (int k = 0; k < 4; k++) begin
                if (wi * 4 + k < int'(cnt)) begin
                    w.data[8*k +: 8] = b[wi*4+k];
                    w.be[k] = 1'b1;
                end
            end
            exp_q.push_back(w);
        end
        start = 1'b1;
        base_addr = base;
        byte_count = cnt;
        @(negedge clk);
        start = 1'b0;
        base_addr = AW'($urandom);
        byte_count = CW'($urandom);
        if (cnt == '0) begin
            chk("zero_done", 64'(done), 64'd1);
            chk("zero_busy", 64'(busy), 64'd0);
            chk("zero_error", 64'(error), 64'd0);
            @(negedge clk);
            chk("zero_done_width", 64'(done), 64'd0);
            chk("zero_words", 64'(words_written), 64'd0);
        end else if (bad) begin
            chk("range_error", 64'(error), 64'd1);
            chk("range_busy", 64'(busy), 64'd0);
            chk("range_in_ready", 64'(in_ready), 64'd0);
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            chk("range_no_done", 64'(seen), 64'd0);
            chk("range_error_sticky", 64'(error), 64'd1);
            chk("range_words", 64'(words_written), 64'd0);
        end else begin
            chk("busy_after_start", 64'(busy), 64'd1);
            chk("error_cleared", 64'(error), 64'd0);
            foreach (b[i]) begin
                in_valid = 1'b0;
                in_data = 8'($urandom);
                repeat ($urandom_range(gmax, gmin)) @(negedge clk);
                in_valid = 1'b1;
                in_data = b[i];
                if (poke && i == 1) begin
                    start = 1'b1;
                    base_addr = base + AW'(7);
                    byte_count = CW'(1);
                end
                t = 0;
                while (!in_ready && t < 20) begin
                    @(negedge clk);
                    start = 1'b0;
                    t++;
                end
                if (t >= 20) chk("accept_timeout", 64'(t), 64'd0);
                chk("busy_in_load", 64'(busy), 64'd1);
                @(negedge clk);
                start = 1'b0;
            end
            in_valid = 1'b0;
            t = 0;
            while (!done && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("done_seen", 64'(done), 64'd1);
            chk("done_in_ready", 64'(in_ready), 64'd0);
            chk("done_busy", 64'(busy), 64'd0);
            chk("words_written", 64'(words_written), 64'(nw));
            chk("error_end", 64'(error), 64'd0);
            chk("writes_pending", 64'(exp_q.size()), 64'd0);
            @(negedge clk);
            chk("done_one_cycle", 64'(done), 64'd0);
        end
        exp_q = {};
        dir_bytes = {};
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_clken", 64'(mem_clken), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_words", 64'(words_written), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("clken_after_reset", 64'(mem_clken), 64'd1);

        // Two full words with continuous valid.
        dir_bytes = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        do_load(AW'(16), CW'(8), 0, 0, 1'b0);
        chk("full_nwrites", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("full_w0", 64'(obs_q[0]), {15'd0, 13'h0010, 32'h44332211, 4'hF});
            chk("full_w1", 64'(obs_q[1]), {15'd0, 13'h0011, 32'h88776655, 4'hF});
        end

        // Partial tail word.
        dir_bytes = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
        do_load(AW'(0), CW'(6), 0, 1, 1'b0);
        chk("tail_nwrites", 64'(obs_q.size()), 64'd2);
        if (obs_q.size() == 2) begin
            chk("tail_w0", 64'(obs_q[0]), {15'd0, 13'h0000, 32'hA4A3A2A1, 4'hF});
            chk("tail_w1", 64'(obs_q[1]), {15'd0, 13'h0001, 32'h0000A6A5, 4'h3});
        end

        do_load(AW'(5), CW'(0), 0, 0, 1'b0);
        do_load(AW'(13'h1FFF), CW'(5), 0, 0, 1'b0);
        do_load(AW'(13'h1FFF), CW'(4), 0, 0, 1'b0);
        chk("top_nwrites", 64'(obs_q.size()), 64'd1);
        if (obs_q.size() == 1) begin
            chk("top_addr", 64'(obs_q[0].addr), 64'h1FFF);
            chk("top_be", 64'(obs_q[0].be), 64'hF);
        end

        // Three idle cycles before every byte.
        do_load(AW'(300), CW'(4), 3, 3, 1'b0);

        // Reset part-way through a load drops it.
        start = 1'b1;
        base_addr = AW'(13'h0100);
        byte_count = CW'(8);
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_write", 64'(mem_write), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_addr", 64'(mem_address), 64'd0);
        chk("mid_rst_clken", 64'(mem_clken), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_clken_back", 64'(mem_clken), 64'd1);
        do_load(AW'(13'h0200), CW'(4), 0, 2, 1'b1);

        for (int it = 0; it < 24; it++) begin
            logic [AW-1:0] rb;
            rb = ($urandom_range(1, 0) == 1) ? AW'($urandom) : AW'(DEPTH - 1 - $urandom_range(12, 0));
            do_load(rb, CW'($urandom_range(48, 0)), 0, 2, 1'($urandom_range(1, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
